// File: rtl/router_pkt_src_if.sv
// router_pkt_src_if: signal bundle between the packet source, its host and
// the router input port.
//   host side   : wr_en, wr_data, start, dest -> source; full, count, idle <- source
//   router side : busy -> source; pkt_data, pkt_valid, done <- source
// The packet source connects through the master modport; the host/router
// model connects through the slave modport.
interface router_pkt_src_if #(
    parameter int WIDTH = 8
);
    localparam int LEN_W = WIDTH - 2;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic [LEN_W-1:0] count;
    logic             start;
    logic [1:0]       dest;
    logic             idle;
    logic             busy;
    logic [WIDTH-1:0] pkt_data;
    logic             pkt_valid;
    logic             done;

    modport master (
        input  wr_en, wr_data, start, dest, busy,
        output full, count, idle, pkt_data, pkt_valid, done
    );

    modport slave (
        output wr_en, wr_data, start, dest, busy,
        input  full, count, idle, pkt_data, pkt_valid, done
    );
endinterface

// File: rtl/router_pkt_src.sv
// router_pkt_src: upstream packet source for the 1x3 router input port.
// The host fills a payload buffer while idle, then requests a packet with a
// destination. The block sends header {count, dest}, the payload words and
// an XOR parity word, holding the current word while the router is busy,
// then waits GAP cycles before accepting the next request.
//
// Ports:
//   clock  - rising-edge clock
//   resetn - asynchronous active-low reset
//   bus    - router_pkt_src_if.master (host write/start, router data/valid/busy)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | accepting buffer writes and start requests
// HEADER  | header word on pkt_data, waiting for busy==0
// PAYLOAD | buffer word rd_ptr on pkt_data, waiting for busy==0
// PARITY  | XOR parity word on pkt_data (pkt_valid=0), waiting for busy==0
// GAP     | fixed idle spacing after a packet, busy ignored
module router_pkt_src #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic               clock,
    input  logic               resetn,
    router_pkt_src_if.master   bus
);
    localparam int LEN_W = WIDTH - 2;
    localparam int DEPTH = (2 ** LEN_W) - 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PARITY  = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] pkt_data_q, pkt_data_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic             done_q, done_d;
    logic             full_q, full_d;
    logic             idle_q, idle_d;

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic             buf_we;

    logic [LEN_W-1:0] next_ptr;
    logic [LEN_W-1:0] last_ptr;
    logic [WIDTH-1:0] par_acc;

    assign next_ptr = rd_ptr_q + LEN_W'(1);
    assign last_ptr = count_q - LEN_W'(1);
    // Parity including the word being consumed this cycle; used both to
    // update the accumulator and to present the parity word without a bubble.
    assign par_acc  = par_q ^ pkt_data_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        par_d       = par_q;
        gap_cnt_d   = gap_cnt_q;
        pkt_data_d  = pkt_data_q;
        pkt_valid_d = pkt_valid_q;
        done_d      = 1'b0;
        buf_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // start has priority; a write in the same cycle is dropped
                if (bus.start && (bus.dest != 2'd3)) begin
                    state_d     = ST_HEADER;
                    pkt_data_d  = {count_q, bus.dest};
                    pkt_valid_d = 1'b1;
                    par_d       = '0;
                end else if (bus.wr_en && !full_q) begin
                    buf_we  = 1'b1;
                    count_d = count_q + LEN_W'(1);
                end
            end

            ST_HEADER: begin
                if (!bus.busy) begin
                    par_d    = par_acc;
                    rd_ptr_d = '0;
                    if (count_q == '0) begin
                        state_d     = ST_PARITY;
                        pkt_data_d  = par_acc;
                        pkt_valid_d = 1'b0;
                    end else begin
                        state_d    = ST_PAYLOAD;
                        pkt_data_d = buf_q[0];
                    end
                end
            end

            ST_PAYLOAD: begin
                if (!bus.busy) begin
                    par_d = par_acc;
                    if (rd_ptr_q == last_ptr) begin
                        state_d     = ST_PARITY;
                        pkt_data_d  = par_acc;
                        pkt_valid_d = 1'b0;
                    end else begin
                        rd_ptr_d   = next_ptr;
                        pkt_data_d = buf_q[next_ptr];
                    end
                end
            end

            ST_PARITY: begin
                if (!bus.busy) begin
                    done_d      = 1'b1;
                    count_d     = '0;
                    rd_ptr_d    = '0;
                    pkt_data_d  = '0;
                    pkt_valid_d = 1'b0;
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                pkt_data_d  = '0;
                pkt_valid_d = 1'b0;
            end
        endcase

        full_d = (count_d == LEN_W'(DEPTH));
        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            par_q       <= '0;
            gap_cnt_q   <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            par_q       <= par_d;
            gap_cnt_q   <= gap_cnt_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            done_q      <= done_d;
            full_q      <= full_d;
            idle_q      <= idle_d;
        end
    end

    // Payload storage has no reset; contents are meaningless until rewritten.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            buf_q[count_q] <= bus.wr_data;
        end
    end

    assign bus.pkt_data  = pkt_data_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.done      = done_q;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.idle      = idle_q;
endmodule

// File: doc/router_pkt_src.md
Name: router_pkt_src

Overview:
Upstream packet source that feeds the 1x3 router core's input port. A host loads payload words into an internal buffer, then issues start with a destination. The block emits a header, the payload words and an XOR parity word on the router's data/pkt_valid inputs, stalling whenever the router asserts busy. It converts a bursty host write interface into the strictly gap-free packet stream the router requires.

Parameters:
WIDTH, 8, data word width; must be at least 3.
GAP, 2, idle cycles inserted after each parity word before the next packet may start; 0 is legal.
(derived) LEN_W = WIDTH-2; DEPTH = 2^LEN_W - 1, the payload buffer capacity and maximum packet length.

Ports:
clock  in  1  single clock; all state on rising edge.
resetn  in  1  reset, asynchronous, active-low.
wr_en  in  1  write wr_data into the payload buffer.
wr_data  in  WIDTH  payload word.
full  out  1  buffer holds DEPTH words.
count  out  LEN_W  words currently buffered.
start  in  1  request transmission of the buffered payload.
dest  in  2  destination port 0..2.
idle  out  1  1 when in IDLE; start and wr_en are accepted only here.
busy  in  1  router back-pressure.
pkt_data  out  WIDTH  word to router data input.
pkt_valid  out  1  high during header and payload words, low on the parity word.
done  out  1  one-cycle pulse at packet completion.

Behaviour:
- Reset values: pkt_data=0, pkt_valid=0, done=0, count=0, full=0, idle=1, state=IDLE. Reset is effective immediately, including mid-packet. Buffer contents are don't-care after reset.
- States: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- IDLE, writes:
  - wr_en=1 and !full stores the word at index count; count increments next cycle.
  - wr_en while full is ignored.
  - wr_en outside IDLE is ignored.
- IDLE, start:
  - start=1 with dest<=2 goes to HEADER next cycle.
  - start with dest==3 is ignored; state stays IDLE.
  - If wr_en and start are both high in the same cycle, start wins and the write is dropped.
- Output register: all outputs are registered. The header appears exactly 1 cycle after start is accepted.
- Word acceptance: a word on pkt_data is consumed at a rising edge where state is HEADER/PAYLOAD/PARITY and busy==0. While busy==1, pkt_data and pkt_valid hold unchanged. This applies in every transmit state, including header and parity.
- HEADER: pkt_data={count[LEN_W-1:0], dest}, pkt_valid=1. When accepted, go to PAYLOAD, or to PARITY if count==0.
- PAYLOAD: pkt_data=buf[rd_ptr], pkt_valid=1. rd_ptr advances on acceptance. After word count-1 is accepted, go to PARITY.
- PARITY: pkt_data = XOR of the header and all payload words, accumulated as words are accepted; pkt_valid=0. When accepted:
  - done=1 for one cycle.
  - count and rd_ptr clear to 0.
  - Go to GAP, or to IDLE if GAP==0.
- GAP: pkt_data=0, pkt_valid=0 for exactly GAP cycles regardless of busy, then IDLE.
- idle is 1 only in IDLE. full == (count==DEPTH).
- Parity accumulator clears at start acceptance.
- pkt_valid never drops between header and last payload word, including under busy stalls and at max length DEPTH.

Test Plan:
- Basic, WIDTH=8: write 0x11,0x22,0x33; start with dest=2 and busy=0 -> cycle+1 pkt_data=0x0E with pkt_valid=1, then 0x11,0x22,0x33 with pkt_valid=1, then 0x0E with pkt_valid=0. done pulses 1 cycle after parity; idle returns after 2 GAP cycles; count=0.
- Busy stall: same packet, busy=1 for 3 cycles during header and 2 cycles on 0x22 -> words held stable, no skip or duplicate, sequence identical, total transmit length grows by 5 cycles.
- Zero-length: start with count=0 and dest=1 -> header 0x01 with pkt_valid=1, then parity 0x01 with pkt_valid=0, then done.
- Full and invalid inputs: write 64 words -> full=1 at count=63 and the 64th write is dropped. start with dest=3 is ignored. Writes while busy sending are dropped. Simultaneous wr_en and start -> count unchanged.
- Reset mid-PAYLOAD: assert resetn=0 -> pkt_valid=0, count=0 and idle=1 asynchronously. The next packet after release is correct.
- Max length (63 words, random data, random busy) -> pkt_valid continuous for 64 words. The parity word equals the scoreboard XOR, and the router shows err=0.
